// File: rtl/ddr_ram_model.sv
// Word-addressed DDR stand-in behind the DMA read/write bridges: 1-cycle reads,
// byte-strobed writes, a backdoor port, saturating traffic counters and a sticky range error.
module ddr_ram_model #(
  parameter int unsigned AXI_WIDTH      = 128,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned BASE_WORD      = 0,
  localparam int unsigned LSB           = $clog2(AXI_WIDTH) - 3,
  localparam int unsigned IW            = $clog2(MEM_WORDS),
  localparam int unsigned AW            = AXI_ADDR_WIDTH - LSB,
  localparam int unsigned NB            = AXI_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 mm2s_ren,
  input  logic [AW-1:0]        mm2s_addr,
  output logic [AXI_WIDTH-1:0] mm2s_data,
  input  logic                 s2mm_wen,
  input  logic [AW-1:0]        s2mm_addr,
  input  logic [AXI_WIDTH-1:0] s2mm_data,
  input  logic [NB-1:0]        s2mm_strb,
  input  logic                 bk_en,
  input  logic                 bk_we,
  input  logic [IW-1:0]        bk_addr,
  input  logic [AXI_WIDTH-1:0] bk_wdata,
  output logic [AXI_WIDTH-1:0] bk_rdata,
  input  logic                 clr_stats,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count,
  output logic [31:0]          wr_bytes,
  output logic                 err_oob,
  output logic [AW-1:0]        err_addr
);

  localparam int unsigned AWX = AW + 1;
  localparam logic [AW:0] BASE_X  = AWX'(BASE_WORD);
  localparam logic [AW:0] LIMIT_X = AWX'(64'(BASE_WORD) + 64'(MEM_WORDS));

  logic [AXI_WIDTH-1:0] mem [MEM_WORDS];

  logic          rd_in, wr_in, rd_oob, wr_oob;
  logic [IW-1:0] rd_idx, wr_idx;
  logic [31:0]   strb_cnt;

  // One extra address bit keeps BASE_WORD+MEM_WORDS from wrapping.
  function automatic logic in_range(input logic [AW-1:0] a);
    logic [AW:0] ax;
    ax = {1'b0, a};
    return (ax >= BASE_X) && (ax < LIMIT_X);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    rd_in    = in_range(mm2s_addr);
    wr_in    = in_range(s2mm_addr);
    rd_oob   = mm2s_ren && !rd_in;
    wr_oob   = s2mm_wen && !wr_in;
    rd_idx   = IW'(mm2s_addr - AW'(BASE_WORD));
    wr_idx   = IW'(s2mm_addr - AW'(BASE_WORD));
    strb_cnt = 32'($countones(s2mm_strb));
  end

  // Strobed s2mm bytes are applied after the backdoor word so they win on overlap.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (bk_en && bk_we) mem[bk_addr] <= bk_wdata;
      if (s2mm_wen && wr_in) begin
        for (int i = 0; i < int'(NB); i++) begin
          if (s2mm_strb[i]) mem[wr_idx][8*i +: 8] <= s2mm_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mm2s_data <= '0;
      bk_rdata  <= '0;
    end else begin
      if (mm2s_ren)        mm2s_data <= rd_in ? mem[rd_idx] : '0;
      if (bk_en && !bk_we) bk_rdata  <= mem[bk_addr];
    end
  end

  // Clear takes priority over any event sampled in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn || clr_stats) begin
      rd_count <= '0;
      wr_count <= '0;
      wr_bytes <= '0;
      err_oob  <= 1'b0;
      err_addr <= '0;
    end else begin
      if (mm2s_ren)          rd_count <= sat_add(rd_count, 32'd1);
      if (s2mm_wen)          wr_count <= sat_add(wr_count, 32'd1);
      if (s2mm_wen && wr_in) wr_bytes <= sat_add(wr_bytes, strb_cnt);
      if (!err_oob && (rd_oob || wr_oob)) begin
        err_oob  <= 1'b1;
        err_addr <= wr_oob ? s2mm_addr : mm2s_addr;
      end
    end
  end

endmodule

// File: tb/tb_ddr_ram_model.sv
// Scoreboard bench for ddr_ram_model: read data expectations are queued at issue
// and popped by a monitor; counters and error state are checked directly.
module tb_ddr_ram_model;

  localparam int unsigned W     = 128;
  localparam int unsigned AW    = 28;
  localparam int unsigned IW    = 12;
  localparam int unsigned NB    = 16;
  localparam int unsigned BASE  = 16;
  localparam int unsigned DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rstn;
  logic          mm2s_ren;
  logic [AW-1:0] mm2s_addr;
  logic [W-1:0]  mm2s_data;
  logic          s2mm_wen;
  logic [AW-1:0] s2mm_addr;
  logic [W-1:0]  s2mm_data;
  logic [NB-1:0] s2mm_strb;
  logic          bk_en, bk_we;
  logic [IW-1:0] bk_addr;
  logic [W-1:0]  bk_wdata, bk_rdata;
  logic          clr_stats;
  logic [31:0]   rd_count, wr_count, wr_bytes;
  logic          err_oob;
  logic [AW-1:0] err_addr;

  ddr_ram_model #(
    .AXI_WIDTH(W), .AXI_ADDR_WIDTH(32), .MEM_WORDS(DEPTH), .BASE_WORD(BASE)
  ) dut (
    .clk(clk), .rstn(rstn),
    .mm2s_ren(mm2s_ren), .mm2s_addr(mm2s_addr), .mm2s_data(mm2s_data),
    .s2mm_wen(s2mm_wen), .s2mm_addr(s2mm_addr), .s2mm_data(s2mm_data), .s2mm_strb(s2mm_strb),
    .bk_en(bk_en), .bk_we(bk_we), .bk_addr(bk_addr), .bk_wdata(bk_wdata), .bk_rdata(bk_rdata),
    .clr_stats(clr_stats), .rd_count(rd_count), .wr_count(wr_count), .wr_bytes(wr_bytes),
    .err_oob(err_oob), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  localparam logic [W-1:0] W5   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [W-1:0] P0   = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] A55  = {16{8'h55}};
  localparam logic [W-1:0] AAA  = {16{8'hAA}};
  localparam logic [W-1:0] C3   = {16{8'hC3}};
  localparam logic [W-1:0] B11  = {16{8'h11}};
  localparam logic [W-1:0] B22  = {16{8'h22}};

  int tests = 0;
  int fails = 0;
  logic [W-1:0] rd_q[$];
  logic [W-1:0] bk_q[$];
  logic rd_pend = 1'b0;
  logic bk_pend = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a read sampled at a rising edge is compared at the following falling edge.
  always @(posedge clk) begin
    rd_pend <= rstn && mm2s_ren;
    bk_pend <= rstn && bk_en && !bk_we;
  end

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL mm2s_data: unexpected read response %h", mm2s_data);
      end else check("mm2s_data", mm2s_data, rd_q.pop_front());
    end
    if (bk_pend) begin
      if (bk_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL bk_rdata: unexpected read response %h", bk_rdata);
      end else check("bk_rdata", bk_rdata, bk_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic bk_write(input logic [IW-1:0] a, input logic [W-1:0] d);
    bk_en = 1'b1; bk_we = 1'b1; bk_addr = a; bk_wdata = d;
    step();
    bk_en = 1'b0; bk_we = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; mm2s_ren = 1'b0; mm2s_addr = '0; s2mm_wen = 1'b0; s2mm_addr = '0;
    s2mm_data = '0; s2mm_strb = '0; bk_en = 1'b0; bk_we = 1'b0; bk_addr = '0;
    bk_wdata = '0; clr_stats = 1'b0;
    step(); step();
    check("reset_mm2s_data", mm2s_data, '0);
    check("reset_bk_rdata", bk_rdata, '0);
    check("reset_rd_count", W'(rd_count), '0);
    check("reset_wr_count", W'(wr_count), '0);
    check("reset_wr_bytes", W'(wr_bytes), '0);
    check("reset_err_oob", W'(err_oob), '0);
    rstn = 1'b1;

    bk_write(12'd0, P0);
    bk_write(12'd3, A55);
    bk_write(12'd5, W5);
    bk_write(12'd7, ONES);
    bk_write(12'd9, C3);

    // Preload and readback through the offset base
    mm2s_ren = 1'b1; mm2s_addr = AW'(BASE + 5); rd_q.push_back(W5);
    step();
    mm2s_ren = 1'b0;
    check("preload_rd_count", W'(rd_count), W'(1));

    // Strobed write: low 8 bytes cleared
    s2mm_wen = 1'b1; s2mm_addr = AW'(BASE + 7); s2mm_data = '0; s2mm_strb = 16'h00FF;
    step();
    s2mm_wen = 1'b0;
    check("strb_wr_count", W'(wr_count), W'(1));
    check("strb_wr_bytes", W'(wr_bytes), W'(8));
    mm2s_ren = 1'b1; mm2s_addr = AW'(BASE + 7); rd_q.push_back({64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    bk_en = 1'b1; bk_we = 1'b0; bk_addr = 12'd7; bk_q.push_back({64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    step();
    mm2s_ren = 1'b0; bk_en = 1'b0;

    // Read-first on same-index read/write
    mm2s_ren = 1'b1; mm2s_addr = AW'(BASE + 3); rd_q.push_back(A55);
    s2mm_wen = 1'b1; s2mm_addr = AW'(BASE + 3); s2mm_data = AAA; s2mm_strb = 16'hFFFF;
    step();
    s2mm_wen = 1'b0; rd_q.push_back(AAA);
    step();
    mm2s_ren = 1'b0;
    check("coll_rd_count", W'(rd_count), W'(4));
    check("coll_wr_bytes", W'(wr_bytes), W'(24));

    // Backdoor vs s2mm on same index: s2mm owns its strobed bytes
    bk_en = 1'b1; bk_we = 1'b1; bk_addr = 12'd11; bk_wdata = B11;
    s2mm_wen = 1'b1; s2mm_addr = AW'(BASE + 11); s2mm_data = B22; s2mm_strb = 16'h000F;
    step();
    s2mm_wen = 1'b0; bk_we = 1'b0; bk_q.push_back({B11[127:32], B22[31:0]});
    step();
    bk_en = 1'b0;
    // Zero-strobe write is a counted no-op
    s2mm_wen = 1'b1; s2mm_addr = AW'(BASE + 8); s2mm_data = ONES; s2mm_strb = '0;
    step();
    s2mm_wen = 1'b0;
    check("nostrb_wr_count", W'(wr_count), W'(4));
    check("nostrb_wr_bytes", W'(wr_bytes), W'(28));
    check("pre_oob_err", W'(err_oob), '0);

    // Out of range: read below base, then write past top
    mm2s_ren = 1'b1; mm2s_addr = AW'(BASE - 1); rd_q.push_back('0);
    step();
    mm2s_ren = 1'b0;
    check("oob_err_oob", W'(err_oob), W'(1));
    check("oob_err_addr", W'(err_addr), W'(BASE - 1));
    check("oob_rd_count", W'(rd_count), W'(5));
    s2mm_wen = 1'b1; s2mm_addr = AW'(BASE + DEPTH); s2mm_data = ONES; s2mm_strb = 16'hFFFF;
    step();
    s2mm_wen = 1'b0;
    check("oob2_err_addr", W'(err_addr), W'(BASE - 1));
    check("oob2_wr_bytes", W'(wr_bytes), W'(28));
    check("oob2_wr_count", W'(wr_count), W'(5));
    bk_en = 1'b1; bk_we = 1'b0; bk_addr = 12'd0; bk_q.push_back(P0);
    step();
    bk_en = 1'b0;

    // Clear wins over a same-cycle out-of-range write
    clr_stats = 1'b1;
    s2mm_wen = 1'b1; s2mm_addr = AW'(BASE + DEPTH); s2mm_strb = 16'hFFFF;
    step();
    clr_stats = 1'b0; s2mm_wen = 1'b0;
    check("clr_err_oob", W'(err_oob), '0);
    check("clr_err_addr", W'(err_addr), '0);
    check("clr_wr_count", W'(wr_count), '0);
    check("clr_rd_count", W'(rd_count), '0);

    // Simultaneous read and write errors: write address recorded
    mm2s_ren = 1'b1; mm2s_addr = AW'(BASE - 1); rd_q.push_back('0);
    s2mm_wen = 1'b1; s2mm_addr = AW'(5000); s2mm_strb = 16'hFFFF;
    step();
    mm2s_ren = 1'b0; s2mm_wen = 1'b0;
    check("both_err_addr", W'(err_addr), W'(5000));
    check("both_rd_count", W'(rd_count), W'(1));
    check("both_wr_bytes", W'(wr_bytes), '0);

    // Saturation from a preset near the top, then clear alongside a read
    force dut.rd_count = 32'hFFFF_FFFE;
    #1;
    release dut.rd_count;
    mm2s_ren = 1'b1; mm2s_addr = AW'(BASE + 5); rd_q.push_back(W5);
    step();
    check("sat1_rd_count", W'(rd_count), W'(32'hFFFF_FFFF));
    rd_q.push_back(W5);
    step();
    check("sat2_rd_count", W'(rd_count), W'(32'hFFFF_FFFF));
    clr_stats = 1'b1; rd_q.push_back(W5);
    step();
    clr_stats = 1'b0; mm2s_ren = 1'b0;
    check("satclr_rd_count", W'(rd_count), '0);

    // Reset mid-stream: write during reset must not land
    mm2s_ren = 1'b1; mm2s_addr = AW'(BASE + 5); rd_q.push_back(W5);
    step();
    rstn = 1'b0;
    s2mm_wen = 1'b1; s2mm_addr = AW'(BASE + 9); s2mm_data = '0; s2mm_strb = 16'hFFFF;
    step();
    rstn = 1'b1; s2mm_wen = 1'b0;
    check("rst_mm2s_data", mm2s_data, '0);
    check("rst_rd_count", W'(rd_count), '0);
    check("rst_wr_count", W'(wr_count), '0);
    rd_q.push_back(W5);
    step();
    mm2s_ren = 1'b0;
    bk_en = 1'b1; bk_we = 1'b0; bk_addr = 12'd9; bk_q.push_back(C3);
    step();
    bk_en = 1'b0;
    step();
    check("post_rst_rd_count", W'(rd_count), W'(1));
    step();
    check("rd_q_drained", W'(rd_q.size()), '0);
    check("bk_q_drained", W'(bk_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
